// File: rtl/nand_pr_elastic.sv
// nand_pr_elastic: DEPTH-entry valid/ready elastic register between NAND CPU pipeline stages.
// Optional feature macro NAND_PR_STALL_COUNT_EN adds a saturating 16-bit stall counter port.
module nand_pr_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef NAND_PR_STALL_COUNT_EN
    ,
    output logic [15:0]                  stall_cycles
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready depends only on occupancy and flush, so no ready path crosses the block.
    assign in_ready  = (count_q != CW'(DEPTH)) && !flush;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[head_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never cleared; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= in_data;
    end

`ifdef NAND_PR_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_nand_pr_elastic.sv
// Scoreboard bench for nand_pr_elastic (WIDTH=32, DEPTH=2); stall test runs only with NAND_PR_STALL_COUNT_EN.
module tb_nand_pr_elastic;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  count;
`ifdef NAND_PR_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sbq[$];

    nand_pr_elastic #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
`ifdef NAND_PR_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Drive point: 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // At the falling edge, book the handshakes that the next rising edge will perform.
    task automatic sb_step(output bit popped, output logic [31:0] exp);
        @(negedge clk);
        popped = 1'b0;
        exp    = '0;
        if (flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                popped = 1'b1;
                exp    = (sbq.size() != 0) ? sbq.pop_front() : 32'hxxxx_xxxx;
            end
            if (in_valid && in_ready) sbq.push_back(in_data);
        end
    endtask

    task automatic test_reset();
        bit          p;
        logic [31:0] e;
        #3;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (count !== 2'd0)     begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
`ifdef NAND_PR_STALL_COUNT_EN
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
        #9 rst = 1'b0;
        cyc();
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b0;
        sb_step(p, e);
        cyc();
        in_valid = 1'b0;
        sb_step(p, e);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL first_out_data: got %h want a5a50001", out_data); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL first_count: got %0d want 1", count); end
        cyc();
        out_ready = 1'b1;
        sb_step(p, e);
        checks++; if (!p || out_data !== e) begin errors++; $display("FAIL first_pop: got %h popped=%b want %h", out_data, p, e); end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        bit          p;
        logic [31:0] e;
        int          npop = 0;
        int          bad  = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            in_valid = 1'b1; in_data = i; out_ready = 1'b1;
            sb_step(p, e);
            if (in_ready !== 1'b1) bad++;
            if (p) begin
                npop++;
                checks++; if (out_data !== e || out_data !== 32'(i - 1)) begin
                    errors++; $display("FAIL stream_data: got %h want %h", out_data, 32'(i - 1));
                end
            end else if (i > 0) begin
                checks++; errors++; $display("FAIL stream_gap: no output at step %0d, want %0d", i, i - 1);
            end
        end
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 5 && (sbq.size() != 0 || out_valid); k++) begin
            sb_step(p, e);
            if (p) begin
                npop++;
                checks++; if (out_data !== e) begin errors++; $display("FAIL stream_tail: got %h want %h", out_data, e); end
            end
            cyc();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_in_ready: dropped %0d times want 0", bad); end
        checks++; if (npop != 100) begin errors++; $display("FAIL stream_count: got %0d pops want 100", npop); end
        checks++; if (sbq.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain: queue=%0d out_valid=%b want 0/0", sbq.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_wrap();
        bit          p;
        logic [31:0] e;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        sb_step(p, e);
        cyc(); in_data = 32'h22;
        sb_step(p, e);
        cyc(); in_data = 32'h33;
        sb_step(p, e);
        checks++; if (count !== 2'd2)    begin errors++; $display("FAIL fill_count: got %0d want 2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        cyc(); out_ready = 1'b1;
        sb_step(p, e);
        checks++; if (in_ready !== 1'b0 || !p || out_data !== 32'h11 || e !== 32'h11) begin
            errors++; $display("FAIL fill_pop11: got %h in_ready=%b want 11 in_ready=0", out_data, in_ready);
        end
        cyc();
        sb_step(p, e);
        checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin
            errors++; $display("FAIL fill_reopen: in_ready=%b count=%0d want 1/1", in_ready, count);
        end
        checks++; if (!p || out_data !== 32'h22 || e !== 32'h22) begin
            errors++; $display("FAIL wrap_22: got %h want 22", out_data);
        end
        cyc(); in_valid = 1'b0;
        sb_step(p, e);
        checks++; if (!p || out_data !== 32'h33 || e !== 32'h33) begin
            errors++; $display("FAIL wrap_33: got %h want 33", out_data);
        end
        cyc(); out_ready = 1'b0;
        sb_step(p, e);
        checks++; if (out_valid !== 1'b0 || sbq.size() != 0) begin
            errors++; $display("FAIL wrap_empty: out_valid=%b queue=%0d want 0/0", out_valid, sbq.size());
        end
    endtask

    task automatic test_flush();
        bit          p;
        logic [31:0] e;
        cyc();
        in_valid = 1'b1; in_data = 32'h44;
        sb_step(p, e);
        cyc(); in_data = 32'h55;
        sb_step(p, e);
        cyc();
        flush = 1'b1; in_data = 32'h66; out_ready = 1'b1;
        sb_step(p, e);
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre: count=%0d in_ready=%b want 2/0", count, in_ready);
        end
        cyc();
        sb_step(p, e);
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_hold: count=%0d out_valid=%b in_ready=%b want 0/0/0", count, out_valid, in_ready);
        end
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        sb_step(p, e);
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_post: count=%0d out_valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bit          p;
        logic [31:0] e;
        in_valid = 1'b1; in_data = 32'h77;
        sb_step(p, e);
        cyc(); in_valid = 1'b0;
        sb_step(p, e);
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL arst_pre: count=%0d want 1", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_now: out_valid=%b count=%0d in_ready=%b want 0/0/1", out_valid, count, in_ready);
        end
        sbq.delete();
        #4 rst = 1'b0;
        cyc();
    endtask

`ifdef NAND_PR_STALL_COUNT_EN
    task automatic test_stall_count();
        bit          p;
        logic [31:0] e;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h88;
        sb_step(p, e);
        cyc(); in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h want ffff", stall_cycles); end
        flush = 1'b1;
        cyc(); flush = 1'b0;
        cyc();
        checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL stall_flush: got %h want ffff", stall_cycles); end
        sbq.delete();
        #2 rst = 1'b1;
        #1;
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL stall_rst: got %h want 0", stall_cycles); end
        #4 rst = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_fill_wrap();
        test_flush();
        test_async_reset();
`ifdef NAND_PR_STALL_COUNT_EN
        test_stall_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
